// File: rtl/vp_centroid_marker.sv
// vp_centroid_marker
//   Streaming stage between vp and hdmi_out. Each pixel is thresholded into a
//   binary mask, first-order moments are accumulated per frame, and the mask
//   centroid is computed by a sequential restoring divider during vertical
//   blanking. A crosshair is overlaid at the last valid centroid. Video timing
//   passes through with exactly one cycle of latency.
//
//   Build option: define CENTROID_BBOX_EN to additionally track the per-frame
//   bounding box of the mask and draw it as a 1-pixel rectangle in the overlay.
module vp_centroid_marker #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter int          COORD_W    = 11,
  parameter int          ACC_W      = 32,
  parameter logic [7:0]  THRESH     = 8'd128,
  parameter int          ARM        = 8,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_in,
  input  logic               h_sync_in,
  input  logic               v_sync_in,
  input  logic [23:0]        pixel_in,
  input  logic [2:0]         sw,
  output logic               de_out,
  output logic               h_sync_out,
  output logic               v_sync_out,
  output logic [23:0]        pixel_out,
  output logic [COORD_W-1:0] centroid_x,
  output logic [COORD_W-1:0] centroid_y,
  output logic               centroid_valid
);

  localparam int                 CNT_W    = (ACC_W > 2) ? $clog2(ACC_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(ACC_W - 1);
  localparam logic [COORD_W-1:0] ARM_C    = COORD_W'(ARM);
  localparam logic [COORD_W:0]   IMG_W_C  = (COORD_W + 1)'(IMG_W);
  localparam logic [COORD_W:0]   IMG_H_C  = (COORD_W + 1)'(IMG_H);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV_X = 2'd1,
    S_DIV_Y = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Saturating coordinate increment: counters stick at the all-ones value.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + {{(COORD_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Output stream registers (also serve as the previous-cycle copies for edge detection)
  logic               r_de;
  logic               r_hs;
  logic               r_vs;
  logic [23:0]        r_pix;
  logic [COORD_W-1:0] r_cx;
  logic [COORD_W-1:0] r_cy;
  logic               r_valid;

  // Coordinate counters
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  // Moment accumulators
  logic [ACC_W-1:0]   r_sum_x;
  logic [ACC_W-1:0]   r_sum_y;
  logic [ACC_W-1:0]   r_cnt;

  // Divider state
  state_t             r_state;
  state_t             w_state_nxt;
  logic [ACC_W-1:0]   r_dvd;
  logic [ACC_W-1:0]   r_rem;
  logic [ACC_W-1:0]   r_div;
  logic [ACC_W-1:0]   r_op_y;
  logic [CNT_W-1:0]   r_bit;
  logic [COORD_W-1:0] r_qx;
  logic               r_skip;

  // Combinational helpers
  logic               w_vs_rise;
  logic               w_de_fall;
  logic               w_mask;
  logic [ACC_W-1:0]   w_x_ext;
  logic [ACC_W-1:0]   w_y_ext;
  logic               w_last_bit;
  logic [ACC_W:0]     w_rem_sh;
  logic [ACC_W:0]     w_div_ext;
  logic               w_ge;
  logic [ACC_W-1:0]   w_rem_nxt;
  logic [ACC_W-1:0]   w_dvd_nxt;
  logic [COORD_W-1:0] w_dx;
  logic [COORD_W-1:0] w_dy;
  logic               w_in_area;
  logic               w_on_cross;
  logic               w_on_box;
  logic               w_overlay;
  logic               w_mark;
  logic               w_unused_sw;

  assign w_unused_sw = &{1'b0, sw[2:1]};

  assign w_vs_rise = v_sync_in & ~r_vs;
  assign w_de_fall = ~de_in & r_de;
  assign w_mask    = de_in & (pixel_in[23:16] >= THRESH);
  assign w_x_ext   = {{(ACC_W-COORD_W){1'b0}}, r_x};
  assign w_y_ext   = {{(ACC_W-COORD_W){1'b0}}, r_y};

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  assign w_last_bit = (r_bit == LAST_BIT);
  assign w_rem_sh   = {r_rem, r_dvd[ACC_W-1]};
  assign w_div_ext  = {1'b0, r_div};
  assign w_ge       = (w_rem_sh >= w_div_ext);
  assign w_rem_nxt  = w_ge ? ACC_W'(w_rem_sh - w_div_ext) : w_rem_sh[ACC_W-1:0];
  assign w_dvd_nxt  = {r_dvd[ACC_W-2:0], w_ge};

  // Pixel coordinate counters: x counts active pixels in a line, y counts lines in a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (de_in) begin
        r_x <= sat_inc(r_x);
      end else begin
        r_x <= '0;
      end
      if (w_vs_rise) begin
        r_y <= '0;
      end else if (w_de_fall) begin
        r_y <= sat_inc(r_y);
      end
    end
  end

  // Moment accumulation; a mask pixel coinciding with the vsync edge seeds the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_x <= '0;
      r_sum_y <= '0;
      r_cnt   <= '0;
    end else if (w_vs_rise) begin
      r_sum_x <= w_mask ? w_x_ext : '0;
      r_sum_y <= w_mask ? w_y_ext : '0;
      r_cnt   <= w_mask ? ACC_W'(1'b1) : '0;
    end else if (w_mask) begin
      r_sum_x <= r_sum_x + w_x_ext;
      r_sum_y <= r_sum_y + w_y_ext;
      r_cnt   <= r_cnt + ACC_W'(1'b1);
    end
  end

  // Divider FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Divider FSM next state; a vsync edge always (re)starts, even mid-division.
  always_comb begin
    w_state_nxt = r_state;
    if (w_vs_rise) begin
      if (r_cnt == '0) begin
        w_state_nxt = S_DONE;
      end else begin
        w_state_nxt = S_DIV_X;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_IDLE;
        end
        S_DIV_X: begin
          if (w_last_bit) begin
            w_state_nxt = S_DIV_Y;
          end else begin
            w_state_nxt = S_DIV_X;
          end
        end
        S_DIV_Y: begin
          if (w_last_bit) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DIV_Y;
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Divider datapath: latch operands on the vsync edge, then run x and y divisions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_op_y <= '0;
      r_bit  <= '0;
      r_qx   <= '0;
      r_skip <= 1'b0;
    end else if (w_vs_rise) begin
      r_dvd  <= r_sum_x;
      r_op_y <= r_sum_y;
      r_div  <= r_cnt;
      r_rem  <= '0;
      r_bit  <= '0;
      r_skip <= (r_cnt == '0);
    end else begin
      case (r_state)
        S_DIV_X: begin
          if (w_last_bit) begin
            r_qx  <= w_dvd_nxt[COORD_W-1:0];
            r_dvd <= r_op_y;
            r_rem <= '0;
            r_bit <= '0;
          end else begin
            r_dvd <= w_dvd_nxt;
            r_rem <= w_rem_nxt;
            r_bit <= r_bit + CNT_W'(1'b1);
          end
        end
        S_DIV_Y: begin
          r_dvd <= w_dvd_nxt;
          r_rem <= w_rem_nxt;
          if (w_last_bit) begin
            r_bit <= '0;
          end else begin
            r_bit <= r_bit + CNT_W'(1'b1);
          end
        end
        default: begin
          r_bit <= r_bit;
        end
      endcase
    end
  end

  // Centroid result: updated only in DONE; an empty frame clears valid but keeps x/y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx    <= '0;
      r_cy    <= '0;
      r_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      if (r_skip) begin
        r_valid <= 1'b0;
      end else begin
        r_cx    <= r_qx;
        r_cy    <= r_dvd[COORD_W-1:0];
        r_valid <= 1'b1;
      end
    end
  end

`ifdef CENTROID_BBOX_EN
  logic [COORD_W-1:0] r_min_x;
  logic [COORD_W-1:0] r_max_x;
  logic [COORD_W-1:0] r_min_y;
  logic [COORD_W-1:0] r_max_y;
  logic [COORD_W-1:0] r_bb_min_x;
  logic [COORD_W-1:0] r_bb_max_x;
  logic [COORD_W-1:0] r_bb_min_y;
  logic [COORD_W-1:0] r_bb_max_y;
  logic               r_bb_ok;
  logic               w_bb_in_x;
  logic               w_bb_in_y;

  // Running bounding box of mask pixels, latched alongside the moments at the vsync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_min_x    <= '1;
      r_max_x    <= '0;
      r_min_y    <= '1;
      r_max_y    <= '0;
      r_bb_min_x <= '0;
      r_bb_max_x <= '0;
      r_bb_min_y <= '0;
      r_bb_max_y <= '0;
      r_bb_ok    <= 1'b0;
    end else if (w_vs_rise) begin
      r_bb_min_x <= r_min_x;
      r_bb_max_x <= r_max_x;
      r_bb_min_y <= r_min_y;
      r_bb_max_y <= r_max_y;
      r_bb_ok    <= (r_cnt != '0);
      if (w_mask) begin
        r_min_x <= r_x;
        r_max_x <= r_x;
        r_min_y <= r_y;
        r_max_y <= r_y;
      end else begin
        r_min_x <= '1;
        r_max_x <= '0;
        r_min_y <= '1;
        r_max_y <= '0;
      end
    end else if (w_mask) begin
      if (r_x < r_min_x) r_min_x <= r_x;
      if (r_x > r_max_x) r_max_x <= r_x;
      if (r_y < r_min_y) r_min_y <= r_y;
      if (r_y > r_max_y) r_max_y <= r_y;
    end
  end

  assign w_bb_in_x = (r_x >= r_bb_min_x) && (r_x <= r_bb_max_x);
  assign w_bb_in_y = (r_y >= r_bb_min_y) && (r_y <= r_bb_max_y);
  assign w_on_box  = r_bb_ok &
                     ((((r_x == r_bb_min_x) || (r_x == r_bb_max_x)) && w_bb_in_y) ||
                      (((r_y == r_bb_min_y) || (r_y == r_bb_max_y)) && w_bb_in_x));
`else
  assign w_on_box = 1'b0;
`endif

  // Crosshair membership test against the previously computed centroid.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (r_x >= r_cx) begin
      w_dx = r_x - r_cx;
    end else begin
      w_dx = r_cx - r_x;
    end
    if (r_y >= r_cy) begin
      w_dy = r_y - r_cy;
    end else begin
      w_dy = r_cy - r_y;
    end
  end

  assign w_in_area  = ({1'b0, r_x} < IMG_W_C) && ({1'b0, r_y} < IMG_H_C);
  assign w_on_cross = ((r_y == r_cy) && (w_dx <= ARM_C)) ||
                      ((r_x == r_cx) && (w_dy <= ARM_C));
  assign w_overlay  = sw[0] & r_valid & de_in & w_in_area;
  assign w_mark     = w_overlay & (w_on_cross | w_on_box);

  // Single pipeline stage for timing and pixel data; timing bits are never altered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_de  <= 1'b0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_pix <= 24'h000000;
    end else begin
      r_de  <= de_in;
      r_hs  <= h_sync_in;
      r_vs  <= v_sync_in;
      r_pix <= w_mark ? MARK_COLOR : pixel_in;
    end
  end

  assign de_out         = r_de;
  assign h_sync_out     = r_hs;
  assign v_sync_out     = r_vs;
  assign pixel_out      = r_pix;
  assign centroid_x     = r_cx;
  assign centroid_y     = r_cy;
  assign centroid_valid = r_valid;

endmodule

// File: tb/tb_vp_centroid_marker.sv
// Directed testbench for vp_centroid_marker (default build, 64x64 frames).
module tb_vp_centroid_marker;

  localparam int CW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          de_in = 1'b0;
  logic          h_sync_in = 1'b0;
  logic          v_sync_in = 1'b0;
  logic [23:0]   pixel_in = 24'h000000;
  logic [2:0]    sw = 3'b000;
  logic          de_out;
  logic          h_sync_out;
  logic          v_sync_out;
  logic [23:0]   pixel_out;
  logic [CW-1:0] centroid_x;
  logic [CW-1:0] centroid_y;
  logic          centroid_valid;

  int total = 0;
  int bad = 0;
  int sync_diff = 0;
  int pass_diff = 0;
  int mon_bad = 0;
  bit mon_en = 1'b0;
  logic [CW-1:0] mon_x = '0;
  logic [CW-1:0] mon_y = '0;
  logic [23:0] obs_pix [0:63][0:63];

  vp_centroid_marker dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .de_in          (de_in),
    .h_sync_in      (h_sync_in),
    .v_sync_in      (v_sync_in),
    .pixel_in       (pixel_in),
    .sw             (sw),
    .de_out         (de_out),
    .h_sync_out     (h_sync_out),
    .v_sync_out     (v_sync_out),
    .pixel_out      (pixel_out),
    .centroid_x     (centroid_x),
    .centroid_y     (centroid_y),
    .centroid_valid (centroid_valid)
  );

  always #5 clk = ~clk;

  // Test image: background has R = 2*x (< 128, never in the mask) plus per-pattern objects.
  function automatic logic [23:0] pix_at(input int pat, input int x, input int y);
    logic [23:0] p;
    p = {8'(x * 2), 8'(y), 8'(x ^ y)};
    case (pat)
      1: if (x == 10 && y == 20) p = 24'hFFFFFF;
      2: begin
        if (x >= 30 && x <= 33 && y >= 40 && y <= 43) p = 24'h800000;
        else if (x == 50 && y == 60) p = 24'h7FFFFF;
      end
      3: if (x == 1 && y == 2) p = 24'hFFFFFF;
      4: if (x == 3 && y == 1) p = 24'hFFFFFF;
      default: ;
    endcase
    return p;
  endfunction

  // Drive one cycle, then observe outputs (which reflect this cycle's inputs) #1 after the edge.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic [23:0] pix, input int px, input int py);
    de_in = de; h_sync_in = hs; v_sync_in = vs; pixel_in = pix;
    @(posedge clk); #1;
    if (de_out !== de || h_sync_out !== hs || v_sync_out !== vs) sync_diff++;
    if (pixel_out !== pix) pass_diff++;
    if (de && px >= 0 && px < 64 && py >= 0 && py < 64) obs_pix[py][px] = pixel_out;
    if (mon_en && (centroid_valid !== 1'b1 || centroid_x !== mon_x || centroid_y !== mon_y))
      mon_bad++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 24'h000000, -1, -1);
  endtask

  // One frame: active lines, then vertical blanking with a vsync pulse.
  task automatic frame(input int pat, input int w, input int h, input int hb,
                       input int vpre, input int vsw, input int vpost);
    sync_diff = 0;
    pass_diff = 0;
    for (int ly = 0; ly < h; ly++) begin
      for (int lx = 0; lx < w; lx++) step(1'b1, 1'b0, 1'b0, pix_at(pat, lx, ly), lx, ly);
      for (int b = 0; b < hb; b++) step(1'b0, (b == 1), 1'b0, 24'h000000, -1, -1);
    end
    for (int i = 0; i < vpre; i++) step(1'b0, 1'b0, 1'b0, 24'h000000, -1, -1);
    for (int i = 0; i < vsw; i++) step(1'b0, 1'b0, 1'b1, 24'h000000, -1, -1);
    for (int i = 0; i < vpost; i++) step(1'b0, 1'b0, 1'b0, 24'h000000, -1, -1);
  endtask

  task automatic big_frame(input int pat);
    frame(pat, 64, 64, 4, 4, 4, 90);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; de_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
    pixel_in = 24'hFFFFFF; sw = 3'b001;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out} !== 27'd0) begin
      bad++;
      $display("FAIL reset_stream: got %h want 0", {de_out, h_sync_out, v_sync_out, pixel_out});
    end
    total++;
    if ({centroid_x, centroid_y, centroid_valid} !== 23'd0) begin
      bad++;
      $display("FAIL reset_centroid: got %h want 0", {centroid_x, centroid_y, centroid_valid});
    end
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 24'h000000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
  endtask

  task automatic test_single_pixel;
    int px[10];
    int py[10];
    bit mk[10];
    logic [23:0] e;
    int errs;
    int dx;
    int dy;
    px = '{10, 2, 18, 10, 10, 1, 19, 10, 10, 11};
    py = '{20, 20, 20, 12, 28, 20, 20, 11, 29, 21};
    mk = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    sw = 3'b001;
    big_frame(1);
    total++;
    if (pass_diff !== 0) begin
      bad++;
      $display("FAIL first_frame_no_marker: got %0d changed pixels want 0", pass_diff);
    end
    total++;
    if (sync_diff !== 0) begin
      bad++;
      $display("FAIL sync_delay_a: got %0d bad cycles want 0", sync_diff);
    end
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b1, 11'd10, 11'd20}) begin
      bad++;
      $display("FAIL single_centroid: got v=%b (%0d,%0d) want v=1 (10,20)",
               centroid_valid, centroid_x, centroid_y);
    end
    big_frame(1);
    total++;
    if (pass_diff !== 33) begin
      bad++;
      $display("FAIL cross_pixel_count: got %0d want 33", pass_diff);
    end
    for (int i = 0; i < 10; i++) begin
      e = mk[i] ? 24'hFF0000 : pix_at(1, px[i], py[i]);
      total++;
      if (obs_pix[py[i]][px[i]] !== e) begin
        bad++;
        $display("FAIL cross_point(%0d,%0d): got %h want %h", px[i], py[i], obs_pix[py[i]][px[i]], e);
      end
    end
    errs = 0;
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        dx = (x > 10) ? x - 10 : 10 - x;
        dy = (y > 20) ? y - 20 : 20 - y;
        e = ((y == 20 && dx <= 8) || (x == 10 && dy <= 8)) ? 24'hFF0000 : pix_at(1, x, y);
        if (obs_pix[y][x] !== e) errs++;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL cross_full_frame: got %0d wrong pixels want 0", errs);
    end
  endtask

  task automatic test_square;
    sw = 3'b001;
    big_frame(2);
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b1, 11'd31, 11'd41}) begin
      bad++;
      $display("FAIL square_centroid: got v=%b (%0d,%0d) want v=1 (31,41)",
               centroid_valid, centroid_x, centroid_y);
    end
  endtask

  task automatic test_black;
    sw = 3'b001;
    big_frame(0);
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b0, 11'd31, 11'd41}) begin
      bad++;
      $display("FAIL black_centroid: got v=%b (%0d,%0d) want v=0 (31,41)",
               centroid_valid, centroid_x, centroid_y);
    end
    big_frame(0);
    total++;
    if (pass_diff !== 0) begin
      bad++;
      $display("FAIL black_no_marker: got %0d changed pixels want 0", pass_diff);
    end
  endtask

  task automatic test_no_overlay;
    sw = 3'b001;
    big_frame(1);
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b1, 11'd10, 11'd20}) begin
      bad++;
      $display("FAIL reacquire_centroid: got v=%b (%0d,%0d) want v=1 (10,20)",
               centroid_valid, centroid_x, centroid_y);
    end
    sw = 3'b000;
    big_frame(1);
    total++;
    if (pass_diff !== 0) begin
      bad++;
      $display("FAIL overlay_off_pass: got %0d changed pixels want 0", pass_diff);
    end
    total++;
    if (sync_diff !== 0) begin
      bad++;
      $display("FAIL sync_delay_b: got %0d bad cycles want 0", sync_diff);
    end
  endtask

  task automatic test_back_to_back_abort;
    sw = 3'b001;
    mon_x = 11'd10;
    mon_y = 11'd20;
    mon_bad = 0;
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) frame(3, 4, 4, 2, 1, 2, 3);
    frame(4, 4, 4, 2, 1, 2, 3);
    mon_en = 1'b0;
    total++;
    if (mon_bad !== 0) begin
      bad++;
      $display("FAIL abort_hold: got %0d cycles with changed centroid want 0", mon_bad);
    end
    idle(90);
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b1, 11'd3, 11'd1}) begin
      bad++;
      $display("FAIL abort_final: got v=%b (%0d,%0d) want v=1 (3,1)",
               centroid_valid, centroid_x, centroid_y);
    end
  endtask

  task automatic test_reset_mid_frame;
    sw = 3'b001;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 24'hFFFFFF, -1, -1);
    rst_n = 1'b0;
    de_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1; pixel_in = 24'hFFFFFF;
    @(posedge clk); #1;
    total++;
    if ({de_out, h_sync_out, v_sync_out, pixel_out} !== 27'd0) begin
      bad++;
      $display("FAIL midreset_stream: got %h want 0", {de_out, h_sync_out, v_sync_out, pixel_out});
    end
    total++;
    if ({centroid_x, centroid_y, centroid_valid} !== 23'd0) begin
      bad++;
      $display("FAIL midreset_centroid: got %h want 0", {centroid_x, centroid_y, centroid_valid});
    end
    de_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; pixel_in = 24'h000000;
    rst_n = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 24'h000000, -1, -1);
    idle(90);
    big_frame(1);
    total++;
    if (pass_diff !== 0) begin
      bad++;
      $display("FAIL postreset_no_marker: got %0d changed pixels want 0", pass_diff);
    end
    total++;
    if ({centroid_valid, centroid_x, centroid_y} !== {1'b1, 11'd10, 11'd20}) begin
      bad++;
      $display("FAIL postreset_centroid: got v=%b (%0d,%0d) want v=1 (10,20)",
               centroid_valid, centroid_x, centroid_y);
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_square();
    test_black();
    test_no_overlay();
    test_back_to_back_abort();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vp_centroid_marker.md
Name: vp_centroid_marker

Overview:
- Streaming stage directly downstream of vp, upstream of hdmi_out; consumes vp's de/h_sync/v_sync/pixel stream.
- Treats each pixel as a binary mask, accumulates first-order moments per frame, and computes the mask centroid with a sequential divider during vertical blanking.
- Overlays a crosshair at the last valid centroid on the passing video. Passes timing through with fixed 1-cycle latency.

Parameters:
- IMG_W, 64, active pixels per line (sim default; 1280 for board).
- IMG_H, 64, active lines per frame.
- COORD_W, 11, width of x/y counters and centroid outputs.
- ACC_W, 32, width of moment accumulators and divider.
- THRESH, 8'd128, mask when pixel_in[23:16] >= THRESH.
- ARM, 8, crosshair half-length in pixels.
- MARK_COLOR, 24'hFF0000, crosshair colour.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- de_in  in  1  data enable from vp.
- h_sync_in  in  1  hsync from vp.
- v_sync_in  in  1  vsync from vp, active high.
- pixel_in  in  24  {R,G,B}.
- sw  in  3  sw[0]=overlay enable; sw[2:1] unused.
- de_out  out  1  de_in delayed 1 cycle.
- h_sync_out  out  1  h_sync_in delayed 1 cycle.
- v_sync_out  out  1  v_sync_in delayed 1 cycle.
- pixel_out  out  24  pixel or MARK_COLOR.
- centroid_x  out  COORD_W  last computed centroid x.
- centroid_y  out  COORD_W  last computed centroid y.
- centroid_valid  out  1  centroid_x/y hold a valid result.

Behaviour:
- Reset (async, rst_n=0): all outputs 0; counters, accumulators, divider cleared; FSM=IDLE.
- Latency: every output stream signal registered exactly once; de/h_sync/v_sync never modified.
- Coordinates: x increments on each de_in=1 cycle and clears when de_in=0. y increments on each de_in falling edge and clears on v_sync_in rising edge. Counters saturate at 2^COORD_W-1.
- Accumulation: on de_in=1 and mask=1, sum_x+=x, sum_y+=y, cnt+=1 (all ACC_W, wrap not expected at parameter limits).
- Frame end: v_sync_in rising edge latches sum_x, sum_y, cnt into divider operands, clears accumulators in the same cycle (a mask pixel coincident with the edge counts toward the new frame), and starts the FSM.
- FSM: IDLE -> DIV_X (ACC_W cycles, restoring division sum_x/cnt) -> DIV_Y (ACC_W cycles, sum_y/cnt) -> DONE (1 cycle: load centroid_x/y from low COORD_W quotient bits, centroid_valid=1) -> IDLE.
- cnt==0 at latch: skip division; go to DONE with centroid_valid=0; centroid_x/y hold previous values.
- New v_sync rising edge while in DIV_X/DIV_Y: abort, relatch the new sums, restart in DIV_X; outputs unchanged until a DONE.
- Quotient is truncated (floor).
- Overlay: when sw[0]=1, centroid_valid=1, de_in=1, and the pixel is on the crosshair, pixel_out=MARK_COLOR; otherwise pixel_out=pixel_in. Crosshair pixels: (y==cy and |x-cx|<=ARM) or (x==cx and |y-cy|<=ARM). Overlay uses the previous frame's centroid.
- sw[0] is sampled per pixel and takes effect immediately.

Optional Feature:
- Macro CENTROID_BBOX_EN.
- Defined: additionally track min/max x and y of mask pixels per frame, latched at the v_sync rising edge with the moments. When overlay is active, draw a 1-pixel MARK_COLOR rectangle on the bounding box. The box is drawn only if cnt>0 in that frame.
- Not defined: no bbox registers or logic; behaviour exactly as above.

Test Plan:
- Reset asserted mid-frame with active video -> all outputs 0 next edge; after release, first frame produces no marker.
- 64x64 frame, single white pixel at (10,20), sw=001 -> after DONE, centroid=(10,20), valid=1; next frame pixel_out=FF0000 at (10,20) and along arms (2..18,20), (10,12..28).
- White 4x4 square at x=30..33, y=40..43 -> centroid=(31,41) (floor of 31.5, 41.5).
- All-black frame -> centroid_valid=0, centroid_x/y unchanged, next frame pixel_out==pixel_in delayed 1 cycle.
- sw=000 with valid centroid -> pixel_out equals pixel_in delayed 1 cycle on all pixels; de/h_sync/v_sync delayed exactly 1 cycle.
- Tiny 4x4 frames with blanking < 2*ACC_W cycles -> divider aborts and restarts; centroid_valid never glitches; result matches last frame that completed.
